// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and packed-port slicing helpers for the
//                parametrised register file and its scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_ZERO       = 0;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    // Low bit of port 'idx' inside a packed bus of 'width'-bit lanes.
    function automatic int port_slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

    function automatic int port_slice_hi(input int idx, input int width);
        return (idx + 1) * width - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register busy bits (set at issue, cleared at writeback,
//                set wins) and the per-read-port busy lookup.
//                Honours REGFILE_BYPASS_EN for same-cycle writeback visibility.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr
);

    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:0] w_busy;

    assign w_busy[REG_ZERO] = 1'b0;

    for (genvar a = 1; a < NREG; a++) begin : g_busy
        logic w_wrHit;
        logic w_issueHit;
        logic r_bit;

        always_comb begin
            w_wrHit = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[port_slice_lo(j, ADDR_W) +: ADDR_W] == ADDR_W'(a))) begin
                    w_wrHit = 1'b1;
                end
            end
        end

        assign w_issueHit = issue_en && (issue_addr == ADDR_W'(a));

        // A new producer issuing in the writeback cycle keeps the bit set.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_bit <= 1'b0;
            end else if (w_issueHit) begin
                r_bit <= 1'b1;
            end else if (w_wrHit) begin
                r_bit <= 1'b0;
            end
        end

        assign w_busy[a] = r_bit;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rdBusy
        logic [ADDR_W-1:0] w_addr;

        assign w_addr = rd_addr[port_slice_lo(i, ADDR_W) +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
        logic w_fwdHit;

        always_comb begin
            w_fwdHit = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (w_addr != ADDR_W'(REG_ZERO)) &&
                    (wr_addr[port_slice_lo(j, ADDR_W) +: ADDR_W] == w_addr)) begin
                    w_fwdHit = 1'b1;
                end
            end
        end

        assign rd_busy[i] = w_fwdHit ? (issue_en && (issue_addr == w_addr)) : w_busy[w_addr];
`else
        assign rd_busy[i] = w_busy[w_addr];
`endif
    end

endmodule
`default_nettype wire

// File: rtl/param_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : param_register_file
//  Description : Parametrised multi-port register file with hardwired zero
//                register and busy scoreboard for hazard stalls.
//                Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] w_regVal [NREG];

    assign w_regVal[REG_ZERO] = '0;

    for (genvar a = 1; a < NREG; a++) begin : g_reg
        logic [DATA_W-1:0] r_value;

        // Later ports override earlier ones, so port 1 wins a same-address conflict.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_value <= '0;
            end else begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && (wr_addr[port_slice_lo(j, ADDR_W) +: ADDR_W] == ADDR_W'(a))) begin
                        r_value <= wr_data[port_slice_lo(j, DATA_W) +: DATA_W];
                    end
                end
            end
        end

        assign w_regVal[a] = r_value;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = rd_addr[port_slice_lo(i, ADDR_W) +: ADDR_W];

        always_comb begin
            w_data = w_regVal[w_addr];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (w_addr != ADDR_W'(REG_ZERO)) &&
                    (wr_addr[port_slice_lo(j, ADDR_W) +: ADDR_W] == w_addr)) begin
                    w_data = wr_data[port_slice_lo(j, DATA_W) +: DATA_W];
                end
            end
`endif
        end

        assign rd_data[port_slice_lo(i, DATA_W) +: DATA_W] = w_data;
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr)
    );

endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_register_file
//  Description : Self-checking bench for param_register_file (2 read, 2 write
//                ports) against an array-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_register_file;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int NREG = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*DW-1:0]   rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*DW-1:0]   wr_data;
    logic                issue_en;
    logic [AW-1:0]       issue_addr;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_regs [NREG];
    logic          m_busy [NREG];

    param_register_file #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NRD),
        .NUM_WR (NWR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0; rd_addr = '0;
    endtask

    task automatic set_rd(input int i, input int a);
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int j, input logic en, input int a, input logic [DW-1:0] d);
        wr_en[j] = en;
        wr_addr[j*AW +: AW] = AW'(a);
        wr_data[j*DW +: DW] = d;
    endtask

    // Reference model: evaluate the architectural rules for the applied inputs,
    // then commit them at the clock edge.
    task automatic step();
        logic [DW-1:0] nregs [NREG];
        logic          nbusy [NREG];
        int a;
        for (int k = 0; k < NREG; k++) begin nregs[k] = m_regs[k]; nbusy[k] = m_busy[k]; end
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin nregs[k] = '0; nbusy[k] = 1'b0; end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                a = int'(wr_addr[j*AW +: AW]);
                if (wr_en[j] && a != 0) begin nregs[a] = wr_data[j*DW +: DW]; nbusy[a] = 1'b0; end
            end
            if (issue_en && issue_addr != 0) nbusy[int'(issue_addr)] = 1'b1;
        end
        @(posedge clk);
        for (int k = 0; k < NREG; k++) begin m_regs[k] = nregs[k]; m_busy[k] = nbusy[k]; end
        #1;
    endtask

    function automatic logic [DW-1:0] exp_data(input int i);
        int a;
        logic [DW-1:0] d;
        a = int'(rd_addr[i*AW +: AW]);
        if (a == 0) return '0;
        d = m_regs[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) d = wr_data[j*DW +: DW];
`endif
        return d;
    endfunction

    function automatic logic exp_busy(input int i);
        int a;
        logic b;
        a = int'(rd_addr[i*AW +: AW]);
        if (a == 0) return 1'b0;
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) b = issue_en && int'(issue_addr) == a;
`endif
        return b;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        set_wr(0, 1'b1, 4, $urandom);
        issue_en = 1'b1; issue_addr = AW'(5);
        step();
        idle();
        set_rd(0, 4); set_rd(1, 5);
        #1;
        checks++; if (rd_data[0 +: DW] !== 32'h0) begin errors++; $display("FAIL reset_data0 got %h exp %h", rd_data[0 +: DW], 32'h0); end
        checks++; if (rd_data[DW +: DW] !== 32'h0) begin errors++; $display("FAIL reset_data1 got %h exp %h", rd_data[DW +: DW], 32'h0); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp %b", rd_busy, 2'b00); end
    endtask

    task automatic test_basic();
        idle();
        set_wr(0, 1'b1, 27, 32'hFFFFFFFF);
        step();
        idle();
        set_rd(1, 27); set_rd(0, 24);
        #1;
        checks++; if (rd_data[DW +: DW] !== 32'hFFFFFFFF) begin errors++; $display("FAIL basic_read27 got %h exp %h", rd_data[DW +: DW], 32'hFFFFFFFF); end
        checks++; if (rd_data[0 +: DW] !== 32'h0) begin errors++; $display("FAIL basic_read24 got %h exp %h", rd_data[0 +: DW], 32'h0); end
    endtask

    task automatic test_zero_reg();
        idle();
        set_wr(1, 1'b1, 0, 32'hDEADBEEF);
        issue_en = 1'b1; issue_addr = '0;
        step();
        idle();
        set_rd(0, 0); set_rd(1, 0);
        #1;
        checks++; if (rd_data[0 +: DW] !== 32'h0) begin errors++; $display("FAIL zero_data got %h exp %h", rd_data[0 +: DW], 32'h0); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL zero_busy got %b exp %b", rd_busy, 2'b00); end
    endtask

    task automatic test_scoreboard();
        idle();
        issue_en = 1'b1; issue_addr = AW'(8);
        step();
        idle();
        set_rd(0, 8);
        #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_set got %b exp %b", rd_busy[0], 1'b1); end
        set_wr(0, 1'b1, 8, 32'h1234);
        step();
        idle(); set_rd(0, 8);
        #1;
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_clear got %b exp %b", rd_busy[0], 1'b0); end
        checks++; if (rd_data[0 +: DW] !== 32'h1234) begin errors++; $display("FAIL sb_data got %h exp %h", rd_data[0 +: DW], 32'h1234); end
        set_wr(0, 1'b1, 8, 32'h1234);
        issue_en = 1'b1; issue_addr = AW'(8);
        step();
        idle(); set_rd(0, 8);
        #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b exp %b", rd_busy[0], 1'b1); end
        checks++; if (rd_data[0 +: DW] !== 32'h1234) begin errors++; $display("FAIL sb_set_wins_data got %h exp %h", rd_data[0 +: DW], 32'h1234); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] expD;
        idle();
        set_wr(0, 1'b1, 9, 32'h11);
        issue_en = 1'b1; issue_addr = AW'(9);
        step();
        idle();
        set_wr(1, 1'b1, 9, 32'hA5A5A5A5);
        set_rd(0, 9);
        #1;
`ifdef REGFILE_BYPASS_EN
        expD = 32'hA5A5A5A5;
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL bypass_busy got %b exp %b", rd_busy[0], 1'b0); end
`else
        expD = 32'h11;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL bypass_busy got %b exp %b", rd_busy[0], 1'b1); end
`endif
        checks++; if (rd_data[0 +: DW] !== expD) begin errors++; $display("FAIL bypass_data got %h exp %h", rd_data[0 +: DW], expD); end
        step();
        idle(); set_rd(0, 9);
        #1;
        checks++; if (rd_data[0 +: DW] !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_after got %h exp %h", rd_data[0 +: DW], 32'hA5A5A5A5); end
    endtask

    task automatic test_dual_write();
        idle();
        set_wr(0, 1'b1, 3, 32'h1);
        set_wr(1, 1'b1, 3, 32'h2);
        step();
        idle(); set_rd(1, 3);
        #1;
        checks++; if (rd_data[DW +: DW] !== 32'h2) begin errors++; $display("FAIL dual_conflict got %h exp %h", rd_data[DW +: DW], 32'h2); end
        rst = 1'b1;
        set_wr(0, 1'b1, 3, 32'h77);
        step();
        idle(); set_rd(1, 3);
        #1;
        checks++; if (rd_data[DW +: DW] !== 32'h0) begin errors++; $display("FAIL rst_over_write got %h exp %h", rd_data[DW +: DW], 32'h0); end
    endtask

    task automatic test_random();
        logic [DW-1:0] ed;
        logic          eb;
        for (int n = 0; n < 400; n++) begin
            idle();
            rst = ($urandom_range(0, 49) == 0);
            for (int j = 0; j < NWR; j++)
                set_wr(j, 1'($urandom), ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31), $urandom);
            issue_en = 1'($urandom);
            issue_addr = AW'($urandom_range(0, 7));
            for (int i = 0; i < NRD; i++) set_rd(i, $urandom_range(0, 7));
            #1;
            for (int i = 0; i < NRD; i++) begin
                ed = exp_data(i);
                eb = exp_busy(i);
                checks++; if (rd_data[i*DW +: DW] !== ed) begin errors++; $display("FAIL rand_data port %0d iter %0d got %h exp %h", i, n, rd_data[i*DW +: DW], ed); end
                checks++; if (rd_busy[i] !== eb) begin errors++; $display("FAIL rand_busy port %0d iter %0d got %b exp %b", i, n, rd_busy[i], eb); end
            end
            step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NREG; k++) begin m_regs[k] = '0; m_busy[k] = 1'b0; end
        idle();
        test_reset();
        test_basic();
        test_zero_reg();
        test_scoreboard();
        test_bypass();
        test_dual_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor to the single-write, dual-read MIPS register file.
- Configurable data width, register count, read-port count and write-port count.
- Register 0 is hardwired to zero.
- Contains a per-register busy scoreboard, set at issue and cleared at writeback, so the hazard unit can stall on pending producers.
- Sits in the ID stage: read ports feed ID/EX, write ports come from WB.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; number of registers NREG = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 1, number of write ports (1..2)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous reset, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  scoreboard busy flag for each read address
- wr_en  in  NUM_WR  per-port write enable (reg_write)
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- issue_en  in  1  an instruction with a destination register leaves ID this cycle
- issue_addr  in  ADDR_W  destination of the issuing instruction

Behaviour:
- Storage: NREG x DATA_W flops. Only one clock, clk, and one synchronous active-high reset, rst.
- Reset: on a rising clk edge with rst=1, all registers and all busy bits clear to 0.
  - rst overrides any wr_en or issue_en in the same cycle.
  - After reset, rd_data = 0 and rd_busy = 0 for every port.
- Write: on a clk edge with wr_en[j]=1 and wr_addr[j]!=0, the register at wr_addr[j] takes wr_data[j].
  - Writes to address 0 are ignored.
- Write-write conflict (NUM_WR=2, same address, both enabled): port 1 wins.
- Read: combinational, zero latency. rd_data[i] = reg[rd_addr[i]].
  - rd_addr[i]=0 always returns 0, regardless of bypass.
- Scoreboard: busy[NREG] flops.
  - issue_en=1 with issue_addr!=0 sets busy[issue_addr] at the next edge.
  - A write to address a clears busy[a] at the same edge it writes data.
  - Issue and write to the same address in the same cycle: set wins (a new producer is in flight); data is still written.
  - busy[0] is constant 0.
- rd_busy[i] = busy[rd_addr[i]], combinational.
- No backpressure: writes and issues are always accepted.
- Issuing to an address that is already busy is legal; the bit stays set.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-to-read forwarding in the same cycle.
  - If any wr_en[j]=1 with wr_addr[j]==rd_addr[i]!=0, rd_data[i]=wr_data[j] (port 1 has priority).
  - rd_busy[i] is forced to 0 for that port that cycle, unless issue_en targets the same address.
- Undefined: reads return the pre-edge register value and the raw busy bit, which reproduces the legacy half-cycle-late visibility.
  - The hazard unit must then stall one extra cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - localparam REG_ZERO = 0
  - default DATA_W and ADDR_W
  - function port_slice helpers for packed-port indexing.
- One natural sub-module, regfile_scoreboard: the busy array with set/clear/priority logic and the rd_busy lookup, instantiated once.
- The data array and bypass muxes stay in the top module.

Test Plan:
- Reset: rst=1 for 1 cycle, then read addresses 4 and 5 -> rd_data=0, rd_busy=0.
- Basic write/read: wr_en=1, wr_addr=27, wr_data=32'hFFFFFFFF.
  - Next cycle rd_addr[1]=27 -> 32'hFFFFFFFF.
  - Address 24 still reads 0.
- Zero register: write 32'hDEADBEEF to address 0 -> a later read of address 0 returns 0; rd_busy stays 0 after issue_addr=0.
- Scoreboard:
  - issue_en, issue_addr=8 -> next cycle rd_busy=1 when reading 8.
  - Write 32'h1234 to 8 -> busy clears on the following cycle.
  - Simultaneous issue and write to 8 -> busy stays 1 and data = 32'h1234.
- Bypass (with REGFILE_BYPASS_EN): in the same cycle wr 9 <- 32'hA5A5A5A5 and rd_addr[0]=9 -> rd_data[0]=32'hA5A5A5A5 and rd_busy[0]=0.
  - Without the macro, the same stimulus returns the old value.
- Dual-write conflict (NUM_WR=2): both ports write address 3 with 32'h1 and 32'h2 -> read returns 32'h2.
  - Asserting rst in the same cycle as a write to 3 -> reg 3 reads 0.
